voice_incr_bank: RTL



---
 rtl/voice_incr_bank.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/voice_incr_bank.sv
// voice_incr_bank
//   Per-voice phase-increment register bank for the DDS voice array.
//   A write routes one M-bit tuning word (plus gate bit) into the shadow
//   register of the selected voice and marks it pending; a commit applies
//   every pending shadow to the active outputs in one cycle.
//
//   Optional feature macro: DDS_VOICE_GLIDE_EN
//     defined   - commit sets a per-voice target; each tick steps the
//                 active word toward it by GLIDE_STEP, clamping at target.
//     undefined - commit loads the active word directly; tick is ignored
//                 and gliding is tied low.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in         tuning word to load
//   sel        target voice index
//   gate_in    gate value loaded with the word
//   wr         write strobe (samples in/sel/gate_in)
//   commit     apply all pending shadow values
//   tick       glide step strobe
//   incr_flat  active words, voice k at [k*M +: M]
//   gate_out   active gate per voice
//   pending    shadow of voice k written since last commit
//   sel_err    sticky: a wr arrived with sel >= N
//   gliding    any voice has active != target
module voice_incr_bank #(
  parameter int M          = 12,
  parameter int N          = 4,
  parameter int SW         = 2,
  parameter int GLIDE_STEP = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [M-1:0]   in,
  input  logic [SW-1:0]  sel,
  input  logic           gate_in,
  input  logic           wr,
  input  logic           commit,
  input  logic           tick,
  output logic [N*M-1:0] incr_flat,
  output logic [N-1:0]   gate_out,
  output logic [N-1:0]   pending,
  output logic           sel_err,
  output logic           gliding
);

  logic [M-1:0] shadow [N];
  logic [M-1:0] active [N];
  logic [N-1:0] sgate;

  int unsigned sel_i;
  logic        sel_ok;

  always_comb begin
    sel_i  = int'(sel);
    sel_ok = (sel_i < N);
  end

`ifdef DDS_VOICE_GLIDE_EN
  localparam logic [M-1:0] STEP = M'(GLIDE_STEP);

  logic [M-1:0] target [N];

  // Step a toward t by STEP, landing exactly on t when within one step.
  function automatic logic [M-1:0] glide_next(input logic [M-1:0] a,
                                              input logic [M-1:0] t);
    if (t > a)      return ((t - a) <= STEP) ? t : a + STEP;
    else if (a > t) return ((a - t) <= STEP) ? t : a - STEP;
    else            return a;
  endfunction

  always_comb begin
    gliding = 1'b0;
    for (int unsigned k = 0; k < N; k++)
      if (active[k] != target[k]) gliding = 1'b1;
  end
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign gliding     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
`ifdef DDS_VOICE_GLIDE_EN
        target[k] <= '0;
`endif
      end
      sgate    <= '0;
      gate_out <= '0;
      pending  <= '0;
      sel_err  <= 1'b0;
    end else begin
`ifdef DDS_VOICE_GLIDE_EN
      // Tick uses the pre-edge target, so a same-cycle commit retargets
      // only from the next tick onward.
      if (tick)
        for (int unsigned k = 0; k < N; k++)
          active[k] <= glide_next(active[k], target[k]);
`endif
      if (commit) begin
        sel_err <= 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
          if (pending[k]) begin
            gate_out[k] <= sgate[k];
`ifdef DDS_VOICE_GLIDE_EN
            target[k]   <= shadow[k];
`else
            active[k]   <= shadow[k];
`endif
            pending[k]  <= 1'b0;
          end
        end
      end
      // Placed after commit so a same-cycle write re-arms pending and an
      // out-of-range write re-sets sel_err.
      if (wr) begin
        if (sel_ok) begin
          for (int unsigned k = 0; k < N; k++) begin
            if (sel_i == k) begin
              shadow[k]  <= in;
              sgate[k]   <= gate_in;
              pending[k] <= 1'b1;
            end
          end
        end else begin
          sel_err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    incr_flat = '0;
    for (int unsigned k = 0; k < N; k++)
      incr_flat[k*M +: M] = active[k];
  end

endmodule
